// File: rtl/memory_access.sv
// memory_access: memory stage of the pipelined RV32I core, between EX/MEM and MEM/WB.
//
// Runs at most one load/store at a time on a variable-latency data-memory bus.
// It steers byte lanes for stores and selects and extends lanes for loads.
// While a transaction waits for its ack, it stalls the upstream pipeline.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   PIP_*_i                  EX/MEM pipeline inputs (controls, address/ALU result, store data, funct3, rd)
//   dmem_req_o/we_o/addr_o/be_o/wdata_o, dmem_rdata_i, dmem_ack_i
//                            data-memory bus
//   mem_stall_o              hold PC, IF/ID, ID/EX and EX/MEM this cycle
//   PIP_*_o                  MEM/WB pipeline register outputs
//   PIP_misaligned_o         one-cycle flag for a dropped misaligned access
//   MEM_WB_operand_o         forwarding value taken from MEM/WB
module memory_access (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PIP_write_mem_i,
  input  logic        PIP_read_mem_i,
  input  logic [31:0] PIP_alu_result_i,
  input  logic [31:0] PIP_second_operand_i,
  input  logic [2:0]  PIP_mem_size_i,
  input  logic        PIP_use_mem_i,
  input  logic        PIP_write_reg_i,
  input  logic [4:0]  PIP_rd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        mem_stall_o,
  output logic        PIP_use_mem_o,
  output logic        PIP_write_reg_o,
  output logic [4:0]  PIP_rd_o,
  output logic [31:0] PIP_alu_result_o,
  output logic [31:0] PIP_mem_data_o,
  output logic        PIP_misaligned_o,
  output logic [31:0] MEM_WB_operand_o
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state, state_next;

  logic        access_pending;
  logic        is_store;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        is_unsigned;
  logic        misaligned;
  logic        aligned_access;
  logic [1:0]  byte_off;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  logic        capture_access;
  logic        insert_bubble;
  logic        flag_misaligned;

  // funct3 decode. Only 000/100 have [1:0]=00, and only 001/101 have [1:0]=01.
  // Every remaining code, including the unused ones, therefore falls into the
  // word class.
  assign access_pending = PIP_read_mem_i | PIP_write_mem_i;
  assign is_store       = PIP_write_mem_i;
  assign is_byte        = (PIP_mem_size_i[1:0] == 2'b00);
  assign is_half        = (PIP_mem_size_i[1:0] == 2'b01);
  assign is_word        = PIP_mem_size_i[1];
  assign is_unsigned    = PIP_mem_size_i[2];
  assign byte_off       = PIP_alu_result_i[1:0];

  assign misaligned     = access_pending &
                          ((is_half & byte_off[0]) | (is_word & (byte_off != 2'b00)));
  assign aligned_access = access_pending & ~misaligned;

  // The bus address, direction and data come straight from EX/MEM.
  // Upstream is frozen by the stall, so these stay stable until the ack.
  assign dmem_we_o   = is_store;
  assign dmem_addr_o = {PIP_alu_result_i[31:2], 2'b00};

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = PIP_second_operand_i;
    if (is_byte) begin
      dmem_be_o    = 4'b0001 << byte_off;
      dmem_wdata_o = {4{PIP_second_operand_i[7:0]}};
    end else if (is_half) begin
      dmem_be_o    = 4'b0011 << {byte_off[1], 1'b0};
      dmem_wdata_o = {2{PIP_second_operand_i[15:0]}};
    end
  end

  // Pick the addressed lane out of the read word and sign- or zero-extend it.
  always_comb begin
    load_byte = dmem_rdata_i[7:0];
    case (byte_off)
      2'd0: load_byte = dmem_rdata_i[7:0];
      2'd1: load_byte = dmem_rdata_i[15:8];
      2'd2: load_byte = dmem_rdata_i[23:16];
      2'd3: load_byte = dmem_rdata_i[31:24];
      default: load_byte = dmem_rdata_i[7:0];
    endcase
    load_half = byte_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    load_ext  = dmem_rdata_i;
    if (is_byte) begin
      load_ext = is_unsigned ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
    end else if (is_half) begin
      load_ext = is_unsigned ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // WAIT is entered only when a request is not acked in its first cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (aligned_access && !dmem_ack_i) state_next = ST_WAIT;
      ST_WAIT: if (dmem_ack_i)                    state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus request, stall and MEM/WB load selection.
  // Holding reset low masks the request and the stall, so an ack that
  // arrives during or after reset finds no request and is ignored.
  always_comb begin
    dmem_req_o      = 1'b0;
    mem_stall_o     = 1'b0;
    capture_access  = 1'b0;
    insert_bubble   = 1'b0;
    flag_misaligned = 1'b0;
    if (reset_n) begin
      case (state)
        ST_IDLE: begin
          if (aligned_access) begin
            dmem_req_o = 1'b1;
            if (dmem_ack_i) begin
              capture_access = 1'b1;
            end else begin
              mem_stall_o   = 1'b1;
              insert_bubble = 1'b1;
            end
          end else if (access_pending) begin
            insert_bubble   = 1'b1;
            flag_misaligned = 1'b1;
          end
        end
        ST_WAIT: begin
          dmem_req_o = 1'b1;
          if (dmem_ack_i) begin
            capture_access = 1'b1;
          end else begin
            mem_stall_o   = 1'b1;
            insert_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // MEM/WB pipeline register.
  // A completed store carries no load data, so its data field is zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      PIP_use_mem_o    <= 1'b0;
      PIP_write_reg_o  <= 1'b0;
      PIP_rd_o         <= 5'd0;
      PIP_alu_result_o <= 32'd0;
      PIP_mem_data_o   <= 32'd0;
      PIP_misaligned_o <= 1'b0;
    end else if (insert_bubble) begin
      PIP_use_mem_o    <= 1'b0;
      PIP_write_reg_o  <= 1'b0;
      PIP_rd_o         <= 5'd0;
      PIP_alu_result_o <= 32'd0;
      PIP_mem_data_o   <= 32'd0;
      PIP_misaligned_o <= flag_misaligned;
    end else begin
      PIP_use_mem_o    <= PIP_use_mem_i;
      PIP_write_reg_o  <= PIP_write_reg_i;
      PIP_rd_o         <= PIP_rd_i;
      PIP_alu_result_o <= PIP_alu_result_i;
      PIP_mem_data_o   <= (capture_access && !is_store) ? load_ext : 32'd0;
      PIP_misaligned_o <= 1'b0;
    end
  end

  assign MEM_WB_operand_o = PIP_use_mem_o ? PIP_mem_data_o : PIP_alu_result_o;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed testbench for memory_access.
//
// A transaction-level reference model runs beside the DUT, and every cycle the
// DUT's outputs are compared against it. Directed scenarios also check
// hand-computed literal values.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        write_mem, read_mem;
  logic [31:0] alu_result, second_operand;
  logic [2:0]  mem_size;
  logic        use_mem, write_reg;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall;
  logic        use_mem_o, write_reg_o;
  logic [4:0]  rd_o;
  logic [31:0] alu_result_o, mem_data_o;
  logic        misaligned_o;
  logic [31:0] operand_o;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  memory_access dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .PIP_write_mem_i      (write_mem),
    .PIP_read_mem_i       (read_mem),
    .PIP_alu_result_i     (alu_result),
    .PIP_second_operand_i (second_operand),
    .PIP_mem_size_i       (mem_size),
    .PIP_use_mem_i        (use_mem),
    .PIP_write_reg_i      (write_reg),
    .PIP_rd_i             (rd),
    .dmem_req_o           (dmem_req),
    .dmem_we_o            (dmem_we),
    .dmem_addr_o          (dmem_addr),
    .dmem_be_o            (dmem_be),
    .dmem_wdata_o         (dmem_wdata),
    .dmem_rdata_i         (dmem_rdata),
    .dmem_ack_i           (dmem_ack),
    .mem_stall_o          (mem_stall),
    .PIP_use_mem_o        (use_mem_o),
    .PIP_write_reg_o      (write_reg_o),
    .PIP_rd_o             (rd_o),
    .PIP_alu_result_o     (alu_result_o),
    .PIP_mem_data_o       (mem_data_o),
    .PIP_misaligned_o     (misaligned_o),
    .MEM_WB_operand_o     (operand_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdm, input logic wrm, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic [2:0] size,
                               input logic um, input logic wr, input logic [4:0] rdst,
                               input logic ack, input logic [31:0] rdata);
    read_mem       = rdm;
    write_mem      = wrm;
    alu_result     = addr;
    second_operand = rs2;
    mem_size       = size;
    use_mem        = um;
    write_reg      = wr;
    rd             = rdst;
    dmem_ack       = ack;
    dmem_rdata     = rdata;
  endtask

  task automatic nop(input logic [31:0] alu, input logic wr, input logic [4:0] rdst);
    applyStimulus(1'b0, 1'b0, alu, 32'h0, 3'b010, 1'b0, wr, rdst, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // busy_m means a bus transaction has been requested and not yet acked.
  bit          busy_m = 1'b0;
  logic        m_use_mem = 1'b0, m_write_reg = 1'b0, m_mis = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_alu = 32'd0, m_data = 32'd0;

  // size class: 1 = byte, 2 = half, 4 = word; sets the unsigned flag
  function automatic int sizeBytes(input logic [2:0] code, output bit uns);
    uns = 1'b0;
    case (code)
      3'b000: return 1;
      3'b100: begin uns = 1'b1; return 1; end
      3'b001: return 2;
      3'b101: begin uns = 1'b1; return 2; end
      default: return 4;
    endcase
  endfunction

  always @(negedge clk) begin
    bit          uns, pend, mis, ereq, estall;
    int          nb;
    int unsigned off, v;
    logic [3:0]  ebe;
    logic [31:0] ewd, eld;
    pend = read_mem || write_mem;
    nb   = sizeBytes(mem_size, uns);
    off  = alu_result % 4;
    mis  = pend && (off % nb != 0);
    ereq   = reset_n && (busy_m || (pend && !mis));
    estall = ereq && !dmem_ack;
    ebe  = (nb == 4) ? 4'hF : ((nb == 2) ? 4'(3 << off) : 4'(1 << off));
    ewd  = (nb == 4) ? second_operand :
           (nb == 2) ? second_operand[15:0] * 32'h0001_0001 : second_operand[7:0] * 32'h0101_0101;
    if (nb == 4) begin
      eld = dmem_rdata;
    end else begin
      v = (dmem_rdata >> (8 * off)) & ((nb == 2) ? 32'hFFFF : 32'hFF);
      if (!uns && nb == 1 && v >= 128)   v = v + 32'hFFFF_FF00;
      if (!uns && nb == 2 && v >= 32768) v = v + 32'hFFFF_0000;
      eld = v;
    end

    if (chk_en) begin
      checkOutput("req", {31'b0, dmem_req}, {31'b0, ereq});
      checkOutput("stall", {31'b0, mem_stall}, {31'b0, estall});
      if (ereq) begin
        checkOutput("we", {31'b0, dmem_we}, {31'b0, write_mem});
        checkOutput("addr", dmem_addr, alu_result & 32'hFFFF_FFFC);
        checkOutput("be", {28'b0, dmem_be}, {28'b0, ebe});
        if (write_mem) checkOutput("wdata", dmem_wdata, ewd);
      end
      checkOutput("use_mem_o", {31'b0, use_mem_o}, {31'b0, m_use_mem});
      checkOutput("write_reg_o", {31'b0, write_reg_o}, {31'b0, m_write_reg});
      checkOutput("rd_o", {27'b0, rd_o}, {27'b0, m_rd});
      checkOutput("alu_result_o", alu_result_o, m_alu);
      checkOutput("mem_data_o", mem_data_o, m_data);
      checkOutput("misaligned_o", {31'b0, misaligned_o}, {31'b0, m_mis});
      checkOutput("operand_o", operand_o, m_use_mem ? m_data : m_alu);
    end

    // what MEM/WB must hold after the coming edge
    if (!reset_n) begin
      busy_m = 0; m_use_mem = 0; m_write_reg = 0; m_rd = 0; m_alu = 0; m_data = 0; m_mis = 0;
    end else if (ereq && !dmem_ack) begin
      busy_m = 1; m_use_mem = 0; m_write_reg = 0; m_rd = 0; m_alu = 0; m_data = 0; m_mis = 0;
    end else if (!ereq && pend && mis) begin
      m_use_mem = 0; m_write_reg = 0; m_rd = 0; m_alu = 0; m_data = 0; m_mis = 1;
    end else begin
      busy_m = 0;
      m_use_mem = use_mem; m_write_reg = write_reg; m_rd = rd; m_alu = alu_result;
      m_data = (ereq && !write_mem) ? eld : 32'd0;
      m_mis = 0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int stall_cycles;
    reset_n = 1'b0;
    nop(32'h0, 1'b0, 5'd0);
    tick();
    chk_en = 1'b1;
    tick();
    checkOutput("reset write_reg_o", {31'b0, write_reg_o}, 32'd0);
    checkOutput("reset alu_result_o", alu_result_o, 32'd0);
    reset_n = 1'b1;

    // zero-wait LW at 0x104
    applyStimulus(1'b1, 1'b0, 32'h104, 32'h0, 3'b010, 1'b1, 1'b1, 5'd3, 1'b1, 32'hDEADBEEF);
    #1;
    checkOutput("lw0 req", {31'b0, dmem_req}, 32'd1);
    checkOutput("lw0 be", {28'b0, dmem_be}, 32'hF);
    checkOutput("lw0 stall", {31'b0, mem_stall}, 32'd0);
    tick();
    nop(32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("lw0 req drop", {31'b0, dmem_req}, 32'd0);
    checkOutput("lw0 data", mem_data_o, 32'hDEADBEEF);
    checkOutput("lw0 operand", operand_o, 32'hDEADBEEF);
    tick();

    // LB at 0x103, ack three cycles after the first request
    stall_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 1'b1, 1'b1, 5'd5, 1'b0, 32'h0);
      #1;
      if (mem_stall) stall_cycles++;
      checkOutput("lb be", {28'b0, dmem_be}, 32'h8);
      tick();
      checkOutput("lb bubble write_reg_o", {31'b0, write_reg_o}, 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 1'b1, 1'b1, 5'd5, 1'b1, 32'h80123456);
    #1;
    if (mem_stall) stall_cycles++;
    tick();
    checkOutput("lb stall cycles", stall_cycles, 32'd3);
    checkOutput("lb data", mem_data_o, 32'hFFFFFF80);
    checkOutput("lb rd", {27'b0, rd_o}, 32'd5);

    // LBU at the same address, one wait cycle
    applyStimulus(1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 1'b1, 1'b1, 5'd6, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 1'b1, 1'b1, 5'd6, 1'b1, 32'h80123456);
    tick();
    checkOutput("lbu data", mem_data_o, 32'h00000080);

    // LH / LHU from the upper half
    applyStimulus(1'b1, 1'b0, 32'h302, 32'h0, 3'b001, 1'b1, 1'b1, 5'd8, 1'b1, 32'h80010000);
    tick();
    checkOutput("lh data", mem_data_o, 32'hFFFF8001);
    applyStimulus(1'b1, 1'b0, 32'h302, 32'h0, 3'b101, 1'b1, 1'b1, 5'd8, 1'b1, 32'h80010000);
    tick();
    checkOutput("lhu data", mem_data_o, 32'h00008001);

    // SH at 0x202, with two wait cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h202, 32'h1234ABCD, 3'b001, 1'b0, 1'b0, 5'd0, (i == 2), 32'h0);
      #1;
      checkOutput("sh wdata", dmem_wdata, 32'hABCDABCD);
      checkOutput("sh be", {28'b0, dmem_be}, 32'hC);
      checkOutput("sh addr", dmem_addr, 32'h200);
      checkOutput("sh we", {31'b0, dmem_we}, 32'd1);
      tick();
    end

    // both read and write set, with an unused size code: a word store
    applyStimulus(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 3'b011, 1'b0, 1'b1, 5'd2, 1'b1, 32'h0);
    #1;
    checkOutput("both we", {31'b0, dmem_we}, 32'd1);
    checkOutput("both be", {28'b0, dmem_be}, 32'hF);
    tick();

    // misaligned LW at 0x102
    applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, 3'b010, 1'b1, 1'b1, 5'd9, 1'b0, 32'h0);
    #1;
    checkOutput("mis req", {31'b0, dmem_req}, 32'd0);
    checkOutput("mis stall", {31'b0, mem_stall}, 32'd0);
    tick();
    checkOutput("mis flag", {31'b0, misaligned_o}, 32'd1);
    checkOutput("mis write_reg_o", {31'b0, write_reg_o}, 32'd0);
    nop(32'h0, 1'b0, 5'd0);
    tick();
    checkOutput("mis flag clear", {31'b0, misaligned_o}, 32'd0);

    // ADD result, no memory access
    nop(32'h55, 1'b1, 5'd7);
    tick();
    checkOutput("add alu", alu_result_o, 32'h55);
    checkOutput("add rd", {27'b0, rd_o}, 32'd7);
    checkOutput("add operand", operand_o, 32'h55);

    // reset while waiting, then a late ack
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h108, 32'h0, 3'b010, 1'b1, 1'b1, 5'd4, 1'b0, 32'h0);
      tick();
    end
    reset_n = 1'b0;
    nop(32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("rst req", {31'b0, dmem_req}, 32'd0);
    checkOutput("rst stall", {31'b0, mem_stall}, 32'd0);
    tick();
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 1'b0, 1'b0, 5'd0, 1'b1, 32'h12345678);
    #1;
    checkOutput("late ack req", {31'b0, dmem_req}, 32'd0);
    checkOutput("late ack stall", {31'b0, mem_stall}, 32'd0);
    tick();
    checkOutput("late ack data", mem_data_o, 32'd0);
    checkOutput("late ack write_reg_o", {31'b0, write_reg_o}, 32'd0);

    nop(32'h0, 1'b0, 5'd0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the pipelined RV32I core: sits between the EX/MEM and MEM/WB pipeline registers. It consumes the execute stage's ALU result, store data and control bits. It runs load/store transactions on a variable-latency data-memory bus with byte-lane steering and sign/zero extension. It stalls the upstream pipeline while a transaction is outstanding and drives the MEM/WB registers plus the MEM/WB forwarding value.

## Interface
- No parameters; data and address width fixed at 32.
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- PIP_write_mem_i  in  1  store request (EX/MEM)
- PIP_read_mem_i  in  1  load request (EX/MEM)
- PIP_alu_result_i  in  32  effective address / ALU result
- PIP_second_operand_i  in  32  store data (forwarded rs2)
- PIP_mem_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes behave as W
- PIP_use_mem_i, PIP_write_reg_i  in  1 each  write-back controls
- PIP_rd_i  in  5  destination register
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word address, {PIP_alu_result_i[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_rdata_i  in  32  read word
- dmem_ack_i  in  1  transaction complete
- mem_stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- PIP_use_mem_o, PIP_write_reg_o  out  1 each  MEM/WB controls
- PIP_rd_o  out  5  MEM/WB rd
- PIP_alu_result_o  out  32  MEM/WB ALU result
- PIP_mem_data_o  out  32  MEM/WB extended load data
- PIP_misaligned_o  out  1  registered misalignment flag, one cycle
- MEM_WB_operand_o  out  32  combinational: PIP_use_mem_o ? PIP_mem_data_o : PIP_alu_result_o

## Operation
- An access is pending when PIP_read_mem_i | PIP_write_mem_i. If both are set, the access is treated as a store.
- Misaligned accesses:
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
  - A misaligned access issues no request and does not stall. The MEM/WB entry is loaded as a bubble and PIP_misaligned_o = 1 for one cycle.
- Byte enables, by size:
  - B: 0001 << addr[1:0]
  - H: 0011 << {addr[1],1'b0}
  - W: 1111
- Store data:
  - B: {4{rs2[7:0]}}
  - H: {2{rs2[15:0]}}
  - W: rs2
- Load data:
  - Select byte addr[1:0] or half addr[1] of dmem_rdata_i.
  - B/H sign-extend; BU/HU zero-extend; W is passed through.
- FSM states: IDLE and WAIT.
  - IDLE, no access pending: dmem_req_o = 0, mem_stall_o = 0. MEM/WB loads the inputs; PIP_mem_data_o loads 0.
  - IDLE, aligned access pending: dmem_req_o = 1 combinationally, with we/addr/be/wdata from the inputs.
    - If dmem_ack_i = 1 in the same cycle (zero-wait), MEM/WB loads at this edge, no stall, and the state stays IDLE.
    - Otherwise mem_stall_o = 1, MEM/WB loads a bubble, and the state goes to WAIT.
  - WAIT: dmem_req_o stays 1; bus outputs come from the inputs, which upstream holds stable under the stall.
    - ack = 0: mem_stall_o = 1, bubble, stay in WAIT.
    - ack = 1: mem_stall_o = 0, MEM/WB loads the access (load data captured from dmem_rdata_i this cycle), go to IDLE.
- A bubble sets PIP_write_reg_o = 0, PIP_use_mem_o = 0, PIP_rd_o = 0, and zeroes the data outputs.
- dmem_ack_i while dmem_req_o = 0 is ignored.

## Timing
- Reset (reset_n low at an edge):
  - State goes to IDLE.
  - All PIP_*_o and PIP_misaligned_o go to 0.
  - dmem_req_o and mem_stall_o are forced to 0 combinationally while reset_n is low.
- Reset during WAIT abandons the transaction; a late ack after reset is ignored.
- Latency:
  - Non-memory instruction: 1 cycle to MEM/WB.
  - Memory access with ack N cycles after the first request cycle (N ≥ 0): N+1 cycles; stall is asserted for N cycles.
- dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o and dmem_wdata_o are stable from the first request cycle through the ack cycle.
- At most one transaction is outstanding; back-to-back accesses may re-request in the cycle after an ack.
- Stores write no register unless PIP_write_reg_i is set; the block passes the bit through unchanged.

## Test plan
- Zero-wait LW (ack same cycle), addr 0x104, rdata 0xDEADBEEF:
  - req for 1 cycle, be 1111, no stall.
  - Next cycle: PIP_mem_data_o = 0xDEADBEEF, MEM_WB_operand_o = 0xDEADBEEF.
- LB at addr 0x103, rdata 0x80123456, ack after 3 cycles:
  - stall high for exactly 3 cycles with 3 bubbles; be = 1000.
  - Result 0xFFFFFF80. LBU at the same address gives 0x00000080.
- SH at addr 0x202, rs2 0x1234ABCD:
  - wdata 0xABCDABCD, be 1100, addr 0x200, we 1.
- LW at addr 0x102:
  - no req, no stall.
  - PIP_misaligned_o = 1 for 1 cycle; PIP_write_reg_o = 0.
- ADD result 0x55 with write_reg = 1, rd = 7, no memory access:
  - Next cycle PIP_alu_result_o = 0x55, PIP_rd_o = 7, MEM_WB_operand_o = 0x55.
- Reset in WAIT, then ack arrives after reset is released:
  - Outputs are 0 and state is IDLE.
  - The late ack produces no MEM/WB load and no stall.
